// File: rtl/noc_inject_adapter.sv
// Per-port injection queues between bursty traffic sources and the NoC input.
// Each port is an independent circular FIFO that drops (and counts) packets offered while full.
module noc_inject_port #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int NF_MARGIN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_val_o,
    output logic              full_o,
    output logic              nearly_full_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]    FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0]    NF_C   = CW'(DEPTH - NF_MARGIN);
    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

    logic [CW-1:0]     count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full, push, pop, drop;

    always_comb begin
        full     = (count_q == FULL_C);
        // Fullness is judged on registered count: a pop in the same cycle does not save the packet.
        push     = in_valid_i && !full;
        drop     = in_valid_i && full;
        pop      = (count_q != '0) && en_i;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        drop_d   = drop_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        if (drop && (drop_q != {CNT_W{1'b1}}))
            drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (reset_n && push)
            mem_q[wr_ptr_q] <= in_data_i;
    end

    assign out_data_o    = mem_q[rd_ptr_q];
    assign out_val_o     = (count_q != '0);
    assign full_o        = full;
    assign nearly_full_o = (count_q >= NF_C);
    assign drop_cnt_o    = drop_q;
endmodule

module noc_inject_adapter #(
    parameter int PORTS     = 16,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int NF_MARGIN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [PORTS-1:0][DATA_W-1:0]  pkt_in_data,
    input  logic [PORTS-1:0]              pkt_in_valid,
    output logic [PORTS-1:0]              net_full,
    output logic [PORTS-1:0]              nearly_full,
    output logic [PORTS-1:0][DATA_W-1:0]  o_data,
    output logic [PORTS-1:0]              o_data_val,
    input  logic [PORTS-1:0]              i_en,
    output logic [PORTS-1:0][CNT_W-1:0]   drop_cnt
);
    for (genvar g = 0; g < PORTS; g++) begin : g_port
        noc_inject_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .NF_MARGIN(NF_MARGIN),
            .CNT_W    (CNT_W)
        ) u_port (
            .clk          (clk),
            .reset_n      (reset_n),
            .in_data_i    (pkt_in_data[g]),
            .in_valid_i   (pkt_in_valid[g]),
            .en_i         (i_en[g]),
            .out_data_o   (o_data[g]),
            .out_val_o    (o_data_val[g]),
            .full_o       (net_full[g]),
            .nearly_full_o(nearly_full[g]),
            .drop_cnt_o   (drop_cnt[g])
        );
    end
endmodule

// File: doc/noc_inject_adapter.md
NOC_INJECT_ADAPTER -- requirements
Module: noc_inject_adapter

Interface
- REQ-001: Parameter PORTS, default 16; number of independent injection channels.
- REQ-002: Parameter DATA_W, default 64; packed packet width per port, valid bit excluded.
- REQ-003: Parameter DEPTH, default 4; per-port queue entries; legal range is 2 and above, power of two not required.
- REQ-004: Parameter NF_MARGIN, default 1; nearly_full asserts at occupancy >= DEPTH-NF_MARGIN; legal range is 0..DEPTH-1.
- REQ-005: Parameter CNT_W, default 16; width of each per-port drop counter.
- REQ-006: clk, input, 1; the single clock; all state updates on its rising edge.
- REQ-007: reset_n, input, 1; reset is synchronous and active-low.
- REQ-008: pkt_in_data, input, [PORTS][DATA_W]; packet offered by the traffic source on each port.
- REQ-009: pkt_in_valid, input, [PORTS]; source-side valid; there is no ready, so the source relies on net_full.
- REQ-010: net_full, output, [PORTS]; port queue is full, and any packet offered this cycle is dropped.
- REQ-011: nearly_full, output, [PORTS]; occupancy threshold flag as defined by NF_MARGIN.
- REQ-012: o_data, output, [PORTS][DATA_W]; head-of-queue packet presented to the network input.
- REQ-013: o_data_val, output, [PORTS]; o_data is valid.
- REQ-014: i_en, input, [PORTS]; network will accept o_data this cycle.
- REQ-015: drop_cnt, output, [PORTS][CNT_W]; saturating count of dropped packets per port.

Function
- REQ-016: Each port SHALL be an independent circular FIFO of DEPTH entries, with no interaction between ports.
- REQ-017: Occupancy count SHALL be $clog2(DEPTH+1) bits wide; read and write pointers SHALL be $clog2(DEPTH) bits wide, minimum 1 bit, and SHALL wrap from DEPTH-1 to 0.
- REQ-018: Push SHALL occur when pkt_in_valid=1 and count<DEPTH; data is written at wr_ptr and wr_ptr advances.
- REQ-019: When pkt_in_valid=1 and count==DEPTH, the packet SHALL be dropped, even if a pop occurs in the same cycle.
- REQ-020: Each drop SHALL increment drop_cnt, saturating at 2^CNT_W-1 with no wrap.
- REQ-021: o_data_val SHALL equal (count!=0).
- REQ-022: o_data SHALL equal mem[rd_ptr], driven from registered state only with no combinational path from pkt_in_data; minimum source-to-network latency is 1 cycle.
- REQ-023: Pop SHALL occur when o_data_val=1 and i_en=1; rd_ptr advances. When o_data_val=0, i_en is ignored.
- REQ-024: On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance; this is legal at any occupancy from 1 to DEPTH-1.
- REQ-025: net_full SHALL equal (count==DEPTH), decoded from registered count.
- REQ-026: nearly_full SHALL equal (count >= DEPTH-NF_MARGIN); with NF_MARGIN=0 it is identical to net_full.
- REQ-027: o_data_val SHALL NOT drop while a packet is held; a head packet stays stable until it is popped.

Reset
- REQ-028: While reset_n=0 at a clk edge, every port SHALL clear its count, rd_ptr, wr_ptr and drop_cnt to 0.
- REQ-029: After that edge, o_data_val=0, net_full=0, nearly_full=0 (or 1 if DEPTH-NF_MARGIN==0, which is illegal) and drop_cnt=0.
- REQ-030: Queue memory contents need not be reset; o_data is don't-care while o_data_val=0.
- REQ-031: Reset asserted mid-operation SHALL discard all queued packets; pkt_in_valid and i_en are ignored during the reset cycle.

Verification (PORTS=4, DATA_W=8, DEPTH=4, NF_MARGIN=1, CNT_W=4)
- REQ-032: Single packet: port 0 offers 0x11 at cycle 0 with i_en=1 -> o_data_val[0]=1 and o_data[0]=0x11 at cycle 1; popped at cycle 1; o_data_val[0]=0 at cycle 2; other ports idle.
- REQ-033: Fill with i_en=0, pushing 0xA0..0xA3 -> nearly_full=1 after the 3rd push, net_full=1 after the 4th; a 5th push of 0xA4 gives drop_cnt=1; draining then yields 0xA0,0xA1,0xA2,0xA3 in order, never 0xA4.
- REQ-034: Full plus simultaneous push and pop (count=4, i_en=1, valid=1) -> packet dropped, count becomes 3, drop_cnt increments.
- REQ-035: Steady streaming (count=2, valid=1, i_en=1 for 10 cycles) -> count stays 2, pointers wrap at least twice, output order is preserved.
- REQ-036: Saturation: 20 drops on port 2 -> drop_cnt[2]=15 and holds; drop_cnt on the other ports stays 0.
- REQ-037: Reset mid-operation (port 1 holds 3 packets, reset_n=0 for 1 cycle) -> o_data_val[1]=0, count=0, drop_cnt=0; the next push appears after 1 cycle.
